// File: rtl/if_fetch_if.sv
// Fetch-stage bundle: instruction-memory port plus
// the decoded fields handed to the IF/ID register.
interface if_fetch_if;
  logic [31:0] i_inst_addr;
  logic [31:0] i_instr;
  logic [31:0] IF_pc;
  logic [5:0]  IF_op;
  logic [5:0]  IF_func;
  logic [4:0]  IF_rs;
  logic [4:0]  IF_rt;
  logic [4:0]  IF_rd;
  logic [15:0] IF_immediate;
  logic [25:0] IF_instrIndex;
  logic        IF_BD;
  logic [4:0]  IF_ExcCode;

  modport master (
    output i_inst_addr,
    input  i_instr,
    output IF_pc,
    output IF_op,
    output IF_func,
    output IF_rs,
    output IF_rt,
    output IF_rd,
    output IF_immediate,
    output IF_instrIndex,
    output IF_BD,
    output IF_ExcCode
  );

  modport slave (
    input  i_inst_addr,
    output i_instr,
    input  IF_pc,
    input  IF_op,
    input  IF_func,
    input  IF_rs,
    input  IF_rt,
    input  IF_rd,
    input  IF_immediate,
    input  IF_instrIndex,
    input  IF_BD,
    input  IF_ExcCode
  );
endinterface

// File: rtl/if_fetch_stage.sv
// P7 MIPS instruction fetch: PC register, next-PC
// select with stall-held redirect, field slicing, AdEL.
module if_fetch_stage #(
  parameter logic [31:0] PC_RESET  = 32'h0000_3000,
  parameter logic [31:0] EXC_ENTRY = 32'h0000_4180,
  parameter logic [31:0] IM_BASE   = 32'h0000_3000,
  parameter logic [31:0] IM_TOP    = 32'h0000_6FFC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        Req,
  input  logic        eret_valid,
  input  logic [31:0] EPC,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic        ID_isBJ,
  if_fetch_if.master  bus
);

  logic [31:0] pc;
  logic        pend;
  logic [31:0] pend_target;
  logic        adel;
  logic [31:0] word;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc          <= PC_RESET;
      pend        <= 1'b0;
      pend_target <= 32'h0;
    end else if (Req) begin
      pc   <= EXC_ENTRY;
      pend <= 1'b0;
    end else if (stall) begin
      // newest capture wins while the PC is frozen
      if (eret_valid) begin
        pend        <= 1'b1;
        pend_target <= EPC;
      end else if (redirect_valid) begin
        pend        <= 1'b1;
        pend_target <= redirect_target;
      end
    end else if (eret_valid) begin
      pc   <= EPC;
      pend <= 1'b0;
    end else if (redirect_valid) begin
      pc   <= redirect_target;
      pend <= 1'b0;
    end else if (pend) begin
      pc   <= pend_target;
      pend <= 1'b0;
    end else begin
      pc <= pc + 32'd4;
    end
  end

  assign adel = (pc[1:0] != 2'b00)
             || (pc < IM_BASE)
             || (pc > IM_TOP);

  // a faulting fetch is squashed to a nop
  assign word = adel ? 32'h0 : bus.i_instr;

  assign bus.i_inst_addr   = pc;
  assign bus.IF_pc         = pc;
  assign bus.IF_op         = word[31:26];
  assign bus.IF_func       = word[5:0];
  assign bus.IF_rs         = word[25:21];
  assign bus.IF_rt         = word[20:16];
  assign bus.IF_rd         = word[15:11];
  assign bus.IF_immediate  = word[15:0];
  assign bus.IF_instrIndex = word[25:0];
  assign bus.IF_BD         = ID_isBJ;
  assign bus.IF_ExcCode    = adel ? 5'd4 : 5'd0;

endmodule
